// File: rtl/ucode_sequencer.sv
// Micro-sequencer: classifies one macro-instruction at a time and steps a
// 2-bit micro-step counter through the class's fixed-length microprogram,
// driving the ROM-select enable and the shared micro-address.
module ucode_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       stall,
  input  logic       abort,
  output logic [1:0] en,
  output logic [3:0] uaddr,
  output logic [3:0] operand,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, EXEC, RETIRE} state_t;

  localparam logic [1:0] CLS_MEM = 2'b11;

  state_t     state, state_n;
  logic [1:0] step, step_n;
  logic [1:0] cls, op;
  logic [1:0] last_step;
  logic       ld;

  // MEM runs three micro-steps, AR/IMM two; step 3 is never reached.
  assign last_step = (cls == CLS_MEM) ? 2'd2 : 2'd1;

  // Next state / step; abort beats everything, including accept and stall.
  always_comb begin
    state_n = state;
    step_n  = step;
    ld      = 1'b0;
    if (abort) begin
      state_n = IDLE;
      step_n  = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ld      = 1'b1;
            step_n  = 2'd0;
            // NOP skips EXEC so en never leaves 00 for it
            state_n = (instr[7:6] == 2'b00) ? RETIRE : EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            if (step == last_step) state_n = RETIRE;
            else                   step_n  = step + 2'd1;
          end
        end
        RETIRE:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State register plus instruction field latches (loaded only on accept).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      step    <= 2'd0;
      cls     <= 2'b00;
      op      <= 2'b00;
      operand <= 4'h0;
    end else begin
      state <= state_n;
      step  <= step_n;
      if (ld) begin
        cls     <= instr[7:6];
        op      <= instr[5:4];
        operand <= instr[3:0];
      end
    end
  end

  // Moore outputs from registered state only.
  assign instr_ready = (state == IDLE);
  assign en          = (state == EXEC) ? cls : 2'b00;
  assign uaddr       = {op, step};
  assign busy        = (state != IDLE);
  assign done        = (state == RETIRE);

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: inputs driven and outputs sampled on
// the falling edge, expected values hand-computed per cycle.
module tb_ucode_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid, instr_ready, stall, abort, busy, done;
  logic [1:0] en;
  logic [3:0] uaddr, operand;

  int checks = 0;
  int errors = 0;

  ucode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stall(stall), .abort(abort), .en(en),
    .uaddr(uaddr), .operand(operand), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // en, uaddr, busy, done, instr_ready in one call
  task automatic chk_out(input string tag, input logic [1:0] e_en, input logic [3:0] e_ua,
                         input logic e_busy, input logic e_done, input logic e_rdy);
    chk({tag, ".en"},    {6'd0, en},          {6'd0, e_en});
    chk({tag, ".uaddr"}, {4'd0, uaddr},       {4'd0, e_ua});
    chk({tag, ".busy"},  {7'd0, busy},        {7'd0, e_busy});
    chk({tag, ".done"},  {7'd0, done},        {7'd0, e_done});
    chk({tag, ".rdy"},   {7'd0, instr_ready}, {7'd0, e_rdy});
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; instr = 8'h00; instr_valid = 1'b0; stall = 1'b0; abort = 1'b0;
    #3;
    chk_out("rst", 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("rst.operand", {4'd0, operand}, 8'h00);
    nxt(); nxt();
    rst_n = 1'b1;

    // AR 0x5A: op=01, operand=A
    nxt(); instr = 8'h5A; instr_valid = 1'b1;
    nxt(); chk_out("ar0", 2'b01, 4'h4, 1'b1, 1'b0, 1'b0);
    chk("ar0.operand", {4'd0, operand}, 8'h0A);
    instr_valid = 1'b0;
    nxt(); chk_out("ar1", 2'b01, 4'h5, 1'b1, 1'b0, 1'b0);
    nxt(); chk_out("ar_ret", 2'b00, 4'h5, 1'b1, 1'b1, 1'b0);
    nxt(); chk_out("ar_idle", 2'b00, 4'h5, 1'b0, 1'b0, 1'b1);

    // MEM 0xE3 with two stalled cycles at uaddr 9
    instr = 8'hE3; instr_valid = 1'b1;
    nxt(); chk_out("mem0", 2'b11, 4'h8, 1'b1, 1'b0, 1'b0);
    instr_valid = 1'b0;
    nxt(); chk_out("mem1", 2'b11, 4'h9, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    nxt(); chk_out("mem_st1", 2'b11, 4'h9, 1'b1, 1'b0, 1'b0);
    nxt(); chk_out("mem_st2", 2'b11, 4'h9, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    nxt(); chk_out("mem2", 2'b11, 4'hA, 1'b1, 1'b0, 1'b0);
    nxt(); chk_out("mem_ret", 2'b00, 4'hA, 1'b1, 1'b1, 1'b0);
    chk("mem.operand", {4'd0, operand}, 8'h03);
    nxt(); chk_out("mem_idle", 2'b00, 4'hA, 1'b0, 1'b0, 1'b1);

    // NOP 0x07 then IMM 0x91 held valid
    instr = 8'h07; instr_valid = 1'b1;
    nxt(); chk_out("nop_ret", 2'b00, 4'h0, 1'b1, 1'b1, 1'b0);
    instr = 8'h91;
    nxt(); chk_out("nop_idle", 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
    nxt(); chk_out("imm0", 2'b10, 4'h4, 1'b1, 1'b0, 1'b0);
    chk("imm.operand", {4'd0, operand}, 8'h01);
    instr_valid = 1'b0;
    nxt(); chk_out("imm1", 2'b10, 4'h5, 1'b1, 1'b0, 1'b0);
    nxt(); chk_out("imm_ret", 2'b00, 4'h5, 1'b1, 1'b1, 1'b0);
    nxt(); chk_out("imm_idle", 2'b00, 4'h5, 1'b0, 1'b0, 1'b1);

    // Abort during MEM step 1, then abort alongside instr_valid in IDLE
    instr = 8'hD6; instr_valid = 1'b1;
    nxt(); chk_out("ab0", 2'b11, 4'h4, 1'b1, 1'b0, 1'b0);
    instr_valid = 1'b0;
    nxt(); chk_out("ab1", 2'b11, 4'h5, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    nxt(); chk_out("ab_idle", 2'b00, 4'h4, 1'b0, 1'b0, 1'b1);
    instr = 8'h5F; instr_valid = 1'b1;
    nxt(); chk_out("ab_noacc", 2'b00, 4'h4, 1'b0, 1'b0, 1'b1);
    chk("ab_noacc.operand", {4'd0, operand}, 8'h06);
    abort = 1'b0; instr_valid = 1'b0;

    // Async reset during IMM step 0
    nxt(); instr = 8'hA5; instr_valid = 1'b1;
    nxt(); chk_out("rs0", 2'b10, 4'h8, 1'b1, 1'b0, 1'b0);
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_out("rs_async", 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("rs_async.operand", {4'd0, operand}, 8'h00);
    nxt(); chk_out("rs_hold", 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // AR 0x6C with garbage instr/instr_valid during EXEC and RETIRE
    instr = 8'h6C; instr_valid = 1'b1;
    nxt(); chk_out("ig0", 2'b01, 4'h8, 1'b1, 1'b0, 1'b0);
    instr = 8'hFF;
    nxt(); chk_out("ig1", 2'b01, 4'h9, 1'b1, 1'b0, 1'b0);
    chk("ig1.operand", {4'd0, operand}, 8'h0C);
    instr = 8'h00;
    nxt(); chk_out("ig_ret", 2'b00, 4'h9, 1'b1, 1'b1, 1'b0);
    instr_valid = 1'b0;
    nxt(); chk_out("ig_idle", 2'b00, 4'h9, 1'b0, 1'b0, 1'b1);
    chk("ig_idle.operand", {4'd0, operand}, 8'h0C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
